// File: rtl/vdma_pkg.sv
// Shared types and helpers for the VDMA read-side line sequencer.
// Holds the FSM state encoding, the default input word geometry and the words-per-line calculation.
package vdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FS,
        ST_WAIT_LS,
        ST_FILL,
        ST_ALIGN,
        ST_RUN
    } state_t;

    localparam int unsigned VDMA_ISIZE      = 256;
    localparam int unsigned VDMA_ISIZE_LOG2 = $clog2(VDMA_ISIZE);

    // FIFO words needed to hold one line. The result is ceil(hact * osize / 2**log2_isize).
    // The product is formed at 64 bits so that it cannot overflow before the shift.
    function automatic logic [31:0] words_per_line(input logic [31:0] hact,
                                                   input int unsigned osize,
                                                   input int unsigned log2_isize);
        logic [63:0] bits;
        bits = 64'(hact) * 64'(osize) + ((64'd1 << log2_isize) - 64'd1);
        return 32'(bits >> log2_isize);
    endfunction

endpackage

// File: rtl/vdma_seq_cnt.sv
// Loadable pixel/line counter pair for the line sequencer.
// Each counter has a terminal-count flag that compares against a last-index value.
module vdma_seq_cnt
    import vdma_pkg::*;
#(
    parameter int unsigned HBITS = 12,
    parameter int unsigned VBITS = 12
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_pix_clr,
    input  logic             i_pix_inc,
    input  logic             i_line_clr,
    input  logic             i_line_inc,
    input  logic [HBITS-1:0] i_pix_last,
    input  logic [VBITS-1:0] i_line_last,
    output logic [HBITS-1:0] o_pix_cnt,
    output logic [VBITS-1:0] o_line_cnt,
    output logic             o_pix_tc,
    output logic             o_line_tc
);

    logic [HBITS-1:0] r_pix;
    logic [VBITS-1:0] r_line;

    // NOTE: registers take non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_pix  <= '0;
            r_line <= '0;
        end else begin
            if (i_pix_clr)
                r_pix <= '0;
            else if (i_pix_inc)
                r_pix <= r_pix + HBITS'(1);

            if (i_line_clr)
                r_line <= '0;
            else if (i_line_inc)
                r_line <= r_line + VBITS'(1);
        end
    end

    assign o_pix_cnt  = r_pix;
    assign o_line_cnt = r_line;
    assign o_pix_tc   = (r_pix == i_pix_last);
    assign o_line_tc  = (r_line == i_line_last);

endmodule

// File: rtl/vdma_line_sequencer.sv
// Read-side line scheduler between the AXI read-data FIFO and the width-reducing unpacker.
// It waits for the frame and line strobes, checks FIFO pre-fill, re-aligns the unpacker and paces pixel reads.
module vdma_line_sequencer
    import vdma_pkg::*;
#(
    parameter int unsigned ISIZE     = VDMA_ISIZE,
    parameter int unsigned OSIZE     = 24,
    parameter int unsigned HBITS     = 12,
    parameter int unsigned VBITS     = 12,
    parameter int unsigned PRE_WORDS = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [HBITS-1:0] hactive,
    input  logic [VBITS-1:0] vactive,
    input  logic             fs,
    input  logic             ls,
    input  logic             ordy,
    input  logic [7:0]       fifo_words,
    output logic             ialign,
    output logic             ord_en,
    output logic             line_end,
    output logic             frame_end,
    output logic [HBITS-1:0] pix_cnt,
    output logic [VBITS-1:0] line_cnt,
    output logic             underflow,
    output logic             ls_miss,
    output logic             cfg_err
);

    localparam int unsigned LOG2_ISIZE = $clog2(ISIZE);

    state_t           r_state;
    logic [HBITS-1:0] r_hact_m1;
    logic [VBITS-1:0] r_vact_m1;
    logic [31:0]      r_fill_need;
    logic             r_underflow;
    logic             r_ls_miss;
    logic             r_cfg_err;

    logic             w_in_frame;
    logic             w_fs_take;
    logic             w_cfg_bad;
    logic             w_run;
    logic             w_ord_en;
    logic             w_pix_tc;
    logic             w_line_tc;
    logic             w_last_pix;
    logic             w_last_line;
    logic             w_fill_ok;
    logic [31:0]      w_words_line;

    assign w_in_frame   = (r_state inside {ST_WAIT_LS, ST_FILL, ST_ALIGN, ST_RUN});
    assign w_fs_take    = enable && fs && (w_in_frame || (r_state == ST_WAIT_FS));
    assign w_cfg_bad    = (hactive == '0) || (vactive == '0);
    assign w_run        = enable && (r_state == ST_RUN);
    assign w_ord_en     = w_run && ordy && (fifo_words != 8'd0);
    assign w_words_line = words_per_line(32'(hactive), OSIZE, LOG2_ISIZE);
    assign w_fill_ok    = (32'(fifo_words) >= r_fill_need);

    // Line/frame end must coincide with the final ord_en, so they are decoded from
    // registered state plus the live read strobe; an accepted fs suppresses them.
    assign w_last_pix  = w_ord_en && w_pix_tc && !w_fs_take;
    assign w_last_line = w_last_pix && w_line_tc;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hact_m1   <= '0;
            r_vact_m1   <= '0;
            r_fill_need <= '0;
            r_underflow <= 1'b0;
            r_ls_miss   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (!enable) begin
                r_state <= ST_IDLE;
            end else if (w_fs_take) begin
                r_underflow <= 1'b0;
                r_ls_miss   <= 1'b0;
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                    r_state   <= ST_WAIT_FS;
                end else begin
                    r_hact_m1   <= hactive - HBITS'(1);
                    r_vact_m1   <= vactive - VBITS'(1);
                    r_fill_need <= (w_words_line < 32'(PRE_WORDS)) ? w_words_line : 32'(PRE_WORDS);
                    r_state     <= ST_WAIT_LS;
                end
            end else begin
                // A line request outside WAIT_LS is dropped, not queued.
                if (ls && (r_state inside {ST_FILL, ST_ALIGN, ST_RUN}))
                    r_ls_miss <= 1'b1;
                if (w_run && ordy && (fifo_words == 8'd0))
                    r_underflow <= 1'b1;

                case (r_state)
                    ST_IDLE:    r_state <= ST_WAIT_FS;
                    ST_WAIT_FS: r_state <= ST_WAIT_FS;
                    ST_WAIT_LS: if (ls) r_state <= ST_FILL;
                    ST_FILL:    if (w_fill_ok) r_state <= ST_ALIGN;
                    ST_ALIGN:   r_state <= ST_RUN;
                    ST_RUN: begin
                        if (w_last_line)
                            r_state <= ST_WAIT_FS;
                        else if (w_last_pix)
                            r_state <= ST_WAIT_LS;
                    end
                    default:    r_state <= ST_IDLE;
                endcase
            end
        end
    end

    vdma_seq_cnt #(
        .HBITS (HBITS),
        .VBITS (VBITS)
    ) u_cnt (
        .clock       (clock),
        .rst         (rst),
        .i_pix_clr   (w_fs_take || (enable && (r_state == ST_ALIGN))),
        .i_pix_inc   (w_ord_en),
        .i_line_clr  (w_fs_take),
        .i_line_inc  (w_last_pix),
        .i_pix_last  (r_hact_m1),
        .i_line_last (r_vact_m1),
        .o_pix_cnt   (pix_cnt),
        .o_line_cnt  (line_cnt),
        .o_pix_tc    (w_pix_tc),
        .o_line_tc   (w_line_tc)
    );

    assign ialign    = enable && (r_state == ST_ALIGN);
    assign ord_en    = w_ord_en;
    assign line_end  = w_last_pix;
    assign frame_end = w_last_line;
    assign underflow = r_underflow;
    assign ls_miss   = r_ls_miss;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_vdma_line_sequencer.sv
// Self-checking bench for vdma_line_sequencer: a pixel scoreboard filled per line,
// a table of fill-threshold vectors, and hand-written sequences for stalls, aborts and reset.
module tb_vdma_line_sequencer;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] hactive = '0;
    logic [11:0] vactive = '0;
    logic        fs = 1'b0;
    logic        ls = 1'b0;
    logic        ordy = 1'b0;
    logic [7:0]  fifo_words = '0;
    logic        ialign, ord_en, line_end, frame_end, underflow, ls_miss, cfg_err;
    logic [11:0] pix_cnt, line_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int ialign_cyc = 0;

    typedef struct {
        int unsigned line;
        int unsigned pix;
        logic        last;
        logic        fend;
    } exp_t;

    typedef struct {
        int unsigned h;
        int unsigned fifo;
        logic        exp_ialign;
    } vec_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t vecs[10];

    vdma_line_sequencer dut (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .hactive    (hactive),
        .vactive    (vactive),
        .fs         (fs),
        .ls         (ls),
        .ordy       (ordy),
        .fifo_words (fifo_words),
        .ialign     (ialign),
        .ord_en     (ord_en),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .pix_cnt    (pix_cnt),
        .line_cnt   (line_cnt),
        .underflow  (underflow),
        .ls_miss    (ls_miss),
        .cfg_err    (cfg_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    // Scoreboard: every read strobe must match the next pixel pushed for the current line.
    always @(negedge clock) begin
        if (!rst) begin
            if (ord_en) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_ord_en");
                end else begin
                    mon_e = q.pop_front();
                    check("sb_pix_cnt", 32'(pix_cnt), mon_e.pix);
                    check("sb_line_cnt", 32'(line_cnt), mon_e.line);
                    check("sb_line_end", 32'(line_end), 32'(mon_e.last));
                    check("sb_frame_end", 32'(frame_end), 32'(mon_e.fend));
                    if (mon_e.pix == 0) first_cyc = cyc_no;
                    last_cyc = cyc_no;
                end
            end else begin
                check("no_end_without_ord_en", {30'd0, line_end, frame_end}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input int unsigned h, input int unsigned v);
        hactive = 12'(h);
        vactive = 12'(v);
        fs = 1'b1;
        cyc();
        fs = 1'b0;
    endtask

    task automatic push_line(input int unsigned l, input int unsigned h, input logic last_line);
        for (int unsigned i = 0; i < h; i++)
            q.push_back('{line: l, pix: i, last: (i == h - 1), fend: last_line && (i == h - 1)});
    endtask

    task automatic issue_ls();
        fifo_words = 8'd8;
        ls = 1'b1;
        cyc();
        ls = 1'b0;
        @(negedge clock);
        check("ialign_not_early", 32'(ialign), 32'd0);
        cyc();
    endtask

    // Starts in the ALIGN cycle. Modes: 0 steady, 1 alternating ordy, 2 FIFO underrun,
    // 3 stray ls at pixel 5, 4 fs abort at pixel 7, 5 reset at pixel 3.
    task automatic drain(input int mode, input int bound);
        for (int c = 0; c < bound; c++) begin
            ordy       = (mode == 1) ? ((c % 2) == 1) : 1'b1;
            fifo_words = (mode == 2 && c >= 6 && c <= 8) ? 8'd0 : 8'd8;
            ls         = (mode == 3 && c == 6);
            fs         = (mode == 4 && c == 8);
            @(negedge clock);
            if (c == 0) begin
                check("ialign_pulse", 32'(ialign), 32'd1);
                ialign_cyc = cyc_no;
            end
            if (c == 1) check("ialign_one_cycle", 32'(ialign), 32'd0);
            if (mode == 2 && c == 7) begin
                check("stall_ord_en", 32'(ord_en), 32'd0);
                check("underflow_set", 32'(underflow), 32'd1);
            end
            if (mode == 3 && c == 7) check("ls_miss_set", 32'(ls_miss), 32'd1);
            if (mode == 4 && c == 9) begin
                check("abort_pix_cnt", 32'(pix_cnt), 32'd0);
                check("abort_line_cnt", 32'(line_cnt), 32'd0);
                check("abort_ord_en", 32'(ord_en), 32'd0);
                q.delete();
                return;
            end
            if (mode == 5 && c == 4) begin
                #1 rst = 1'b1;
                #1;
                check("rst_ord_en", 32'(ord_en), 32'd0);
                check("rst_ialign", 32'(ialign), 32'd0);
                check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
                check("rst_line_cnt", 32'(line_cnt), 32'd0);
                check("rst_flags", {26'd0, line_end, frame_end, underflow, ls_miss, cfg_err}, 32'd0);
                q.delete();
                return;
            end
            cyc();
            if (q.size() == 0) return;
        end
        fail_now("drain_timeout");
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{h: 10,   fifo: 1, exp_ialign: 1'b1};
        vecs[1] = '{h: 10,   fifo: 0, exp_ialign: 1'b0};
        vecs[2] = '{h: 16,   fifo: 1, exp_ialign: 1'b0};
        vecs[3] = '{h: 16,   fifo: 2, exp_ialign: 1'b1};
        vecs[4] = '{h: 11,   fifo: 1, exp_ialign: 1'b0};
        vecs[5] = '{h: 32,   fifo: 2, exp_ialign: 1'b1};
        vecs[6] = '{h: 32,   fifo: 1, exp_ialign: 1'b0};
        vecs[7] = '{h: 1,    fifo: 1, exp_ialign: 1'b1};
        vecs[8] = '{h: 4095, fifo: 2, exp_ialign: 1'b1};
        vecs[9] = '{h: 4095, fifo: 1, exp_ialign: 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ialign", 32'(ialign), 32'd0);
        check("reset_ord_en", 32'(ord_en), 32'd0);
        check("reset_pix_cnt", 32'(pix_cnt), 32'd0);
        check("reset_line_cnt", 32'(line_cnt), 32'd0);
        check("reset_flags", {26'd0, line_end, frame_end, underflow, ls_miss, cfg_err}, 32'd0);
        cyc();
        rst = 1'b0;
        enable = 1'b1;
        fifo_words = 8'd8;
        ordy = 1'b1;
        cyc();

        // Two full lines of 32 pixels, back-to-back ls
        start_frame(32, 2);
        push_line(0, 32, 1'b0);
        issue_ls();
        drain(0, 100);
        check("first_ord_after_ialign", 32'(first_cyc - ialign_cyc), 32'd1);
        check("line0_consecutive", 32'(last_cyc - first_cyc), 32'd31);
        check("line_cnt_after_l0", 32'(line_cnt), 32'd1);
        check("pix_cnt_end_of_line", 32'(pix_cnt), 32'd32);
        push_line(1, 32, 1'b1);
        issue_ls();
        drain(0, 100);
        check("line_cnt_after_frame", 32'(line_cnt), 32'd2);

        // Alternating ordy, 10 pixels over 20 cycles
        start_frame(10, 1);
        push_line(0, 10, 1'b1);
        issue_ls();
        drain(1, 100);
        check("alt_span", 32'(last_cyc - first_cyc), 32'd18);
        check("alt_no_errors", {30'd0, underflow, ls_miss}, 32'd0);

        // Pre-fill gating, then FIFO underrun mid-line
        ordy = 1'b1;
        start_frame(16, 1);
        fifo_words = 8'd1;
        ls = 1'b1;
        cyc();
        ls = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("fill_hold_no_ialign", 32'(ialign), 32'd0);
            cyc();
        end
        fifo_words = 8'd2;
        cyc();
        push_line(0, 16, 1'b1);
        drain(2, 100);
        check("underflow_sticky", 32'(underflow), 32'd1);

        // Stray ls during RUN
        start_frame(10, 1);
        check("underflow_cleared_by_fs", 32'(underflow), 32'd0);
        push_line(0, 10, 1'b1);
        issue_ls();
        drain(3, 100);
        check("ls_miss_sticky", 32'(ls_miss), 32'd1);

        // fs abort at line 1 pixel 7, then a fresh frame
        start_frame(10, 2);
        check("ls_miss_cleared_by_fs", 32'(ls_miss), 32'd0);
        push_line(0, 10, 1'b0);
        issue_ls();
        drain(0, 100);
        push_line(1, 10, 1'b1);
        issue_ls();
        drain(4, 100);
        push_line(0, 10, 1'b0);
        issue_ls();
        drain(0, 100);
        push_line(1, 10, 1'b1);
        issue_ls();
        drain(0, 100);

        // Zero hactive: cfg_err pulse and no line start
        hactive = 12'd0;
        vactive = 12'd2;
        fs = 1'b1;
        cyc();
        fs = 1'b0;
        @(negedge clock);
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        cyc();
        @(negedge clock);
        check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
        ls = 1'b1;
        cyc();
        ls = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("cfg_err_no_ialign", 32'(ialign), 32'd0);
            cyc();
        end
        check("cfg_err_no_ls_miss", 32'(ls_miss), 32'd0);

        // Asynchronous reset in the middle of a line
        start_frame(32, 1);
        push_line(0, 32, 1'b1);
        issue_ls();
        drain(5, 100);
        cyc();
        rst = 1'b0;

        // Fill-threshold table
        for (int i = 0; i < 10; i++) begin
            ordy = 1'b0;
            fifo_words = 8'(vecs[i].fifo);
            enable = 1'b1;
            cyc();
            start_frame(vecs[i].h, 1);
            ls = 1'b1;
            cyc();
            ls = 1'b0;
            cyc();
            @(negedge clock);
            check($sformatf("tbl_ialign_h%0d_f%0d", vecs[i].h, vecs[i].fifo), 32'(ialign), 32'(vecs[i].exp_ialign));
            enable = 1'b0;
            #1;
            check("ialign_gated_by_enable", 32'(ialign), 32'd0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
